// File: rtl/audio_sample_fifo_if.sv
// Frame-level bus between an audio producer/I2S serializer pair and the sample FIFO.
// Write side: a frame transfers on any rising clk edge where wr_valid && wr_ready; the
// producer holds wr_left/wr_right stable while wr_valid is high and wr_ready is low.
interface audio_sample_fifo_if #(
  parameter int WIDTH = 16
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_left;
  logic [WIDTH-1:0] wr_right;
  logic             frame_req;
  logic             frame_ack;
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] right_out;

  modport master (
    output wr_valid, wr_left, wr_right, frame_req,
    input  wr_ready, frame_ack, left_out, right_out
  );

  modport slave (
    input  wr_valid, wr_left, wr_right, frame_req,
    output wr_ready, frame_ack, left_out, right_out
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO feeding an I2S serializer: primes to PRIME_LEVEL before playback,
// mutes while filling, and counts underruns when the serializer outpaces the producer.
module audio_sample_fifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                   clk,
  input  logic                   sys_rst_i,
  audio_sample_fifo_if.slave     bus,
  input  logic                   clear_underrun,
  output logic [$clog2(DEPTH):0] level,
  output logic                   playing,
  output logic [7:0]             underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  typedef enum logic {FILL = 1'b0, PLAY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             ack_q, ack_d;
  logic             req_q;
  logic [7:0]       urun_q, urun_d;

  logic [WIDTH-1:0] mem_l [DEPTH];
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic wr_ready;
  logic wr_fire;
  logic req_edge;
  logic pop;

  assign wr_ready = (level_q != FULL_LVL);
  assign wr_fire  = bus.wr_valid && wr_ready;
  // Only the first cycle of a frame_req pulse counts, however long it is held.
  assign req_edge = bus.frame_req && !req_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    left_d   = left_q;
    right_d  = right_q;
    ack_d    = 1'b0;
    urun_d   = urun_q;
    pop      = 1'b0;

    case (state_q)
      FILL: begin
        if (req_edge) begin
          left_d  = '0;
          right_d = '0;
          ack_d   = 1'b1;
        end
        if (level_q >= PRIME_LVL) state_d = PLAY;
      end
      PLAY: begin
        if (req_edge) begin
          ack_d = 1'b1;
          if (level_q != '0) begin
            pop     = 1'b1;
            left_d  = mem_l[rd_ptr_q];
            right_d = mem_r[rd_ptr_q];
          end else begin
            // Underrun: a write landing in this same cycle is still kept below.
            left_d  = '0;
            right_d = '0;
            state_d = FILL;
            if (urun_q != 8'hFF) urun_d = urun_q + 8'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase

    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_fire, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (clear_underrun) urun_d = 8'd0;
  end

  always_ff @(posedge clk or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      ack_q    <= 1'b0;
      req_q    <= 1'b0;
      urun_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      left_q   <= left_d;
      right_q  <= right_d;
      ack_q    <= ack_d;
      req_q    <= bus.frame_req;
      urun_q   <= urun_d;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_fire && !sys_rst_i) begin
      mem_l[wr_ptr_q] <= bus.wr_left;
      mem_r[wr_ptr_q] <= bus.wr_right;
    end
  end

  assign bus.wr_ready  = wr_ready;
  assign bus.frame_ack = ack_q;
  assign bus.left_out  = left_q;
  assign bus.right_out = right_q;
  assign level          = level_q;
  assign playing        = (state_q == PLAY);
  assign underrun_count = urun_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: a queue-based reference model predicts every
// acked frame, the occupancy, the play state and the underrun counter cycle by cycle.
module tb_audio_sample_fifo;
  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int PRIME = 8;

  logic       clk = 1'b0;
  logic       sys_rst_i = 1'b1;
  logic       clear_underrun = 1'b0;
  logic [4:0] level;
  logic       playing;
  logic [7:0] underrun_count;

  audio_sample_fifo_if #(.WIDTH(W)) bus();

  audio_sample_fifo #(.WIDTH(W), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .clk            (clk),
    .sys_rst_i      (sys_rst_i),
    .bus            (bus),
    .clear_underrun (clear_underrun),
    .level          (level),
    .playing        (playing),
    .underrun_count (underrun_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int step     = 0;

  // scoreboard and reference state
  logic [2*W-1:0] exp_q[$];
  int             m_level;
  bit             m_play;
  int             m_urun;
  bit             m_req_prev;
  logic [W-1:0]   m_left;
  logic [W-1:0]   m_right;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level    = 0;
    m_play     = 1'b0;
    m_urun     = 0;
    m_req_prev = 1'b0;
    m_left     = '0;
    m_right    = '0;
  endtask

  task automatic chk_all();
    chk("level", 32'(level), 32'(m_level));
    chk("playing", 32'(playing), 32'(m_play));
    chk("underrun_count", 32'(underrun_count), 32'(m_urun));
    chk("wr_ready", 32'(bus.wr_ready), 32'(m_level != DEPTH));
    chk("left_out", 32'(bus.left_out), 32'(m_left));
    chk("right_out", 32'(bus.right_out), 32'(m_right));
  endtask

  task automatic apply_reset();
    bus.wr_valid   = 1'b0;
    bus.frame_req  = 1'b0;
    clear_underrun = 1'b0;
    #2;
    sys_rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst_frame_ack", 32'(bus.frame_ack), 32'd0);
    chk_all();
    repeat (2) @(posedge clk);
    #3;
    sys_rst_i = 1'b0;
    @(posedge clk);
    #1;
    chk_all();
  endtask

  // driver: one clock of stimulus, model update, and checks just after the edge
  task automatic drive_cycle(input bit wr, input logic [W-1:0] l, input logic [W-1:0] r,
                             input bit req, input bit clr);
    int             lb;
    bit             ack_e;
    bit             nxt_play;
    logic [2*W-1:0] e;
    step++;
    bus.wr_valid   = wr;
    bus.wr_left    = l;
    bus.wr_right   = r;
    bus.frame_req  = req;
    clear_underrun = clr;
    lb         = m_level;
    ack_e      = req && !m_req_prev;
    m_req_prev = req;
    nxt_play   = m_play;
    if (ack_e) begin
      e = '0;
      if (m_play && lb > 0) begin
        e = exp_q.pop_front();
        m_level--;
      end else if (m_play) begin
        nxt_play = 1'b0;
        if (m_urun < 255) m_urun++;
      end
      m_left  = e[2*W-1:W];
      m_right = e[W-1:0];
    end
    if (!m_play && lb >= PRIME) nxt_play = 1'b1;
    if (wr && lb < DEPTH) begin
      exp_q.push_back({l, r});
      m_level++;
    end
    if (clr) m_urun = 0;
    m_play = nxt_play;
    @(posedge clk);
    #1;
    bus.wr_valid   = 1'b0;
    clear_underrun = 1'b0;
    chk("frame_ack", 32'(bus.frame_ack), 32'(ack_e));
    chk_all();
  endtask

  task automatic write(input logic [W-1:0] l, input logic [W-1:0] r);
    drive_cycle(1'b1, l, r, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic urun_round(input bit clr_on_urun, input int base);
    for (int n = 0; n < PRIME; n++) write(W'(base + n), W'(base + 16'h0100 + n));
    idle();
    for (int n = 0; n < PRIME; n++) frame();
    drive_cycle(1'b0, '0, '0, 1'b1, clr_on_urun);
    idle();
  endtask

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_left   = '0;
    bus.wr_right  = '0;
    bus.frame_req = 1'b0;
    model_reset();

    apply_reset();

    // muted frames while filling; level untouched
    for (int n = 0; n < 3; n++) write(W'(16'h3000 + n), W'(16'h3100 + n));
    frame();
    chk("fill_level_3", 32'(level), 32'd3);

    // priming, held request, simultaneous write and pop at level 5
    apply_reset();
    for (int n = 0; n < 8; n++) write(W'(16'h1000 + n), W'(16'h2000 + n));
    idle();
    chk("primed_playing", 32'(playing), 32'd1);
    frame();
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle();
    frame();
    chk("level_before_simul", 32'(level), 32'd5);
    drive_cycle(1'b1, 16'h1100, 16'h2100, 1'b1, 1'b0);
    idle();
    chk("level_after_simul", 32'(level), 32'd5);
    for (int n = 0; n < 5; n++) frame();
    frame();

    // full backpressure, order, pointer wrap, write into empty during underrun
    apply_reset();
    for (int n = 0; n < 17; n++) write(W'(16'h4000 + n), W'(16'h5000 + n));
    chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    for (int n = 0; n < 16; n++) frame();
    for (int n = 0; n < 4; n++) write(W'(16'h6000 + n), W'(16'h6100 + n));
    for (int n = 0; n < 4; n++) frame();
    drive_cycle(1'b1, 16'h6A6A, 16'h6B6B, 1'b1, 1'b0);
    idle();
    chk("urun_write_kept", 32'(level), 32'd1);

    // underrun counting, saturation, clear, clear priority
    apply_reset();
    urun_round(1'b0, 16'h8000);
    chk("first_underrun", 32'(underrun_count), 32'd1);
    for (int k = 0; k < 255; k++) urun_round(1'b0, 16'h8000 + 16 * k);
    chk("urun_saturated", 32'(underrun_count), 32'd255);
    drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("urun_cleared", 32'(underrun_count), 32'd0);
    urun_round(1'b0, 16'hC000);
    urun_round(1'b1, 16'hD000);
    chk("clear_priority", 32'(underrun_count), 32'd0);

    // asynchronous reset mid-stream at level 10
    apply_reset();
    for (int n = 0; n < 10; n++) write(W'(16'h7000 + n), W'(16'h7100 + n));
    idle();
    frame();
    write(16'h7777, 16'h7878);
    chk("pre_reset_level", 32'(level), 32'd10);
    #3;
    sys_rst_i = 1'b1;
    #1;
    model_reset();
    chk("async_rst_ack", 32'(bus.frame_ack), 32'd0);
    chk_all();
    @(posedge clk);
    #3;
    sys_rst_i = 1'b0;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning sample width in bits (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 16, meaning stereo-frame capacity; power of two, minimum 4.
REQ-003 SHALL have parameter PRIME_LEVEL, default 8, meaning fill level required before playback starts; range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock (6 MHz); all logic on its rising edge.
REQ-005 SHALL have port sys_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port wr_valid, input, 1 bit: the producer offers a frame.
REQ-007 SHALL have port wr_ready, output, 1 bit: the FIFO can accept a frame.
REQ-008 SHALL have ports wr_left and wr_right, input, WIDTH bits each: the offered left and right samples.
REQ-009 SHALL have port frame_req, input, 1 bit: single-cycle pulse from the I2S serializer at each frame start.
REQ-010 SHALL have ports left_out and right_out, output, WIDTH bits each: the held samples for the serializer.
REQ-011 SHALL have port frame_ack, output, 1 bit: single-cycle pulse when left_out/right_out are updated.
REQ-012 SHALL have port level, output, log2(DEPTH)+1 bits: the current occupancy.
REQ-013 SHALL have port playing, output, 1 bit: high in state PLAY.
REQ-014 SHALL have port underrun_count, output, 8 bits: saturating underrun counter.
REQ-015 SHALL have port clear_underrun, input, 1 bit: synchronous clear of underrun_count.

Function
REQ-016 SHALL store frames in a circular buffer with read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 SHALL drive wr_ready = (level != DEPTH), combinationally from registered state.
REQ-018 SHALL accept a write when wr_valid && wr_ready: store the frame at the write pointer, advance the pointer, and add 1 to level; wr_valid while full SHALL be ignored with no state change.
REQ-019 SHALL implement a state machine with states FILL and PLAY.
REQ-020 SHALL, in FILL on frame_req: load zero into left_out/right_out, pulse frame_ack, and not pop.
REQ-021 SHALL move from FILL to PLAY on the cycle after level >= PRIME_LEVEL is registered.
REQ-022 SHALL, in PLAY on frame_req with level > 0: pop the head frame into left_out/right_out, advance the read pointer, subtract 1 from level, and pulse frame_ack.
REQ-023 SHALL, in PLAY on frame_req with level == 0 (underrun): load zeros, pulse frame_ack, increment underrun_count (saturating at 255), and move to FILL.
REQ-024 SHALL have a latency of one clock: left_out, right_out and frame_ack update on the edge after the cycle in which frame_req is sampled high.
REQ-025 SHALL hold left_out/right_out stable between frame_acks.
REQ-026 SHALL, on a write and a pop in the same cycle, leave level unchanged and perform both operations.
REQ-027 SHALL allow a simultaneous write to an empty FIFO and frame_req in PLAY: this counts as an underrun, and the written frame is retained.
REQ-028 SHALL ignore frame_req held high longer than one cycle beyond its first cycle: act on the rising edge of frame_req only.
REQ-029 SHALL give clear_underrun priority over an increment in the same cycle: the result is 0.
REQ-030 SHALL not change level on frame_req in FILL.

Reset
REQ-031 SHALL, on sys_rst_i high, immediately set: pointers 0, level 0, state FILL, left_out/right_out 0, frame_ack 0, playing 0, underrun_count 0, wr_ready 1.
REQ-032 SHALL discard buffer contents on reset; reset asserted mid-operation SHALL abort any pending pop or write.
REQ-033 SHALL release reset without requiring any storage-array initialization.

Verification
REQ-034 SHALL be verified by priming: write 8 frames (L=0x1000+n, R=0x2000+n), then frame_req -> playing=1; ack one cycle later with left_out=0x1000, right_out=0x2000; level=7.
REQ-035 SHALL be verified by a FILL mute test: write 3 frames, then pulse frame_req -> outputs 0x0000, frame_ack=1, level stays 3, playing=0.
REQ-036 SHALL be verified by full backpressure: write 17 frames back-to-back -> wr_ready=0 after the 16th, level=16, the 17th is not stored; pop order returns frames 0..15, and pointers wrap correctly.
REQ-037 SHALL be verified by underrun: prime with 8, pop 9 times -> the 9th outputs zeros, underrun_count=1, state FILL; 255 further underruns -> count holds at 255; clear_underrun -> 0.
REQ-038 SHALL be verified by simultaneous write and pop at level=5 -> level stays 5 and data order is preserved.
REQ-039 SHALL be verified by reset mid-stream: assert sys_rst_i asynchronously between clock edges with level=10 -> outputs are zero and level=0 immediately, without waiting for a clock edge.
